vote_cipher: RTL and testbench



---
 rtl/vote_cipher_if.sv | 35 +++
 rtl/vote_cipher.sv | 103 ++++++++++
 tb/tb_vote_cipher.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vote_cipher_if.sv
// Record/key handshake bundle for vote_cipher.
// out_tag exists only when VOTE_CIPHER_TAG_EN is defined.
interface vote_cipher_if;
  logic [0:63] key_in;
  logic        key_load;
  logic        key_ready;
  logic        in_valid;
  logic        in_ready;
  logic [0:63] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] out_data;
  logic        busy;
`ifdef VOTE_CIPHER_TAG_EN
  logic [0:7]  out_tag;

  modport master (
    output key_in, key_load, in_valid, in_data, out_ready,
    input  key_ready, in_ready, out_valid, out_data, busy, out_tag
  );
  modport slave (
    input  key_in, key_load, in_valid, in_data, out_ready,
    output key_ready, in_ready, out_valid, out_data, busy, out_tag
  );
`else
  modport master (
    output key_in, key_load, in_valid, in_data, out_ready,
    input  key_ready, in_ready, out_valid, out_data, busy
  );
  modport slave (
    input  key_in, key_load, in_valid, in_data, out_ready,
    output key_ready, in_ready, out_valid, out_data, busy
  );
`endif
endinterface

// File: rtl/vote_cipher.sv
// Iterative XOR/rotate vote-record cipher, one round per clock.
// Optional plaintext byte-XOR tag output enabled by VOTE_CIPHER_TAG_EN.
//
// state | meaning
// IDLE  | waiting for key load / plaintext record
// RUN   | applying rounds, r counts 0..ROUNDS-1
// DONE  | ciphertext presented, held until out_ready
module vote_cipher #(
  parameter int ROUNDS = 8
) (
  input logic    clk,
  input logic    rst,
  vote_cipher_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [0:63] key_q;
  logic        key_ready_q;
  logic [0:63] s_q;
  logic [0:63] rk_q;
  logic [7:0]  r_q;
  logic [0:63] t;
  logic        accept;
  logic        last_round;
  logic        in_ready_c;

  assign t          = s_q ^ rk_q;
  assign last_round = (r_q == 8'(ROUNDS - 1));

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = key_ready_q;
        accept     = key_ready_q & bus.in_valid;
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (last_round) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The record always captures the key register as it was before this edge,
  // so a same-cycle key_load only affects later records.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      key_ready_q <= 1'b0;
      s_q         <= '0;
      rk_q        <= '0;
      r_q         <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.key_load) begin
        key_q       <= bus.key_in;
        key_ready_q <= 1'b1;
      end
      if (accept) begin
        s_q  <= bus.in_data;
        rk_q <= key_q;
        r_q  <= '0;
      end else if (state_q == RUN) begin
        s_q  <= {t[8:63], t[0:7]};
        rk_q <= {rk_q[1:63], rk_q[0]} ^ {56'b0, r_q};
        r_q  <= r_q + 8'd1;
      end
    end
  end

`ifdef VOTE_CIPHER_TAG_EN
  logic [0:7] tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else if (accept) begin
      tag_q <= bus.in_data[0:7]   ^ bus.in_data[8:15]  ^
               bus.in_data[16:23] ^ bus.in_data[24:31] ^
               bus.in_data[32:39] ^ bus.in_data[40:47] ^
               bus.in_data[48:55] ^ bus.in_data[56:63];
    end
  end

  assign bus.out_tag = tag_q;
`endif

  assign bus.key_ready = key_ready_q;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = s_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vote_cipher.sv
// Directed bench for vote_cipher: a ROUNDS=1 and a ROUNDS=8 instance share
// stimulus; sel picks which instance's outputs are checked.
module tb_vote_cipher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key_in = '0;
  logic        key_load = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vote_cipher_if i1 ();
  vote_cipher_if i8 ();

  assign i1.key_in    = key_in;
  assign i1.key_load  = key_load;
  assign i1.in_valid  = in_valid;
  assign i1.in_data   = in_data;
  assign i1.out_ready = out_ready;
  assign i8.key_in    = key_in;
  assign i8.key_load  = key_load;
  assign i8.in_valid  = in_valid;
  assign i8.in_data   = in_data;
  assign i8.out_ready = out_ready;

  vote_cipher #(.ROUNDS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  vote_cipher #(.ROUNDS(8)) u_dut8 (.clk(clk), .rst(rst), .bus(i8.slave));

  logic        o_key_ready, o_in_ready, o_out_valid, o_busy;
  logic [63:0] o_data;
  logic [7:0]  o_tag;

  always_comb begin
    o_key_ready = sel ? i8.key_ready : i1.key_ready;
    o_in_ready  = sel ? i8.in_ready  : i1.in_ready;
    o_out_valid = sel ? i8.out_valid : i1.out_valid;
    o_busy      = sel ? i8.busy      : i1.busy;
    o_data      = sel ? i8.out_data  : i1.out_data;
`ifdef VOTE_CIPHER_TAG_EN
    o_tag       = sel ? i8.out_tag   : i1.out_tag;
`else
    o_tag       = 8'h00;
`endif
  end

  function automatic logic [63:0] ref_cipher(input logic [63:0] k, input logic [63:0] d,
                                             input int rounds);
    logic [63:0] s, rk, t;
    s  = d;
    rk = k;
    for (int i = 0; i < rounds; i++) begin
      t  = s ^ rk;
      s  = {t[55:0], t[63:56]};
      rk = {rk[62:0], rk[63]} ^ 64'(i[7:0]);
    end
    return s;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, ".key_ready"}, 64'(o_key_ready), 64'd0);
    check_val({tag, ".in_ready"},  64'(o_in_ready),  64'd0);
    check_val({tag, ".out_valid"}, 64'(o_out_valid), 64'd0);
    check_val({tag, ".out_data"},  o_data,           64'd0);
    check_val({tag, ".busy"},      64'(o_busy),      64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_key(input logic [63:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check_val("load_key.key_ready", 64'(o_key_ready), 64'd1);
    check_val("load_key.in_ready",  64'(o_in_ready),  64'd1);
  endtask

  // Presents a record (optionally with a same-cycle key_load), checks the
  // accept-to-out_valid latency and returns the ciphertext seen in DONE.
  task automatic send_rec(input string tag, input logic [63:0] d, input logic ld,
                          input logic [63:0] ld_key, input int lat,
                          output logic [63:0] res);
    int c;
    check_val({tag, ".in_ready_pre"}, 64'(o_in_ready), 64'd1);
    in_data  = d;
    in_valid = 1'b1;
    key_in   = ld_key;
    key_load = ld;
    tick();
    in_valid = 1'b0;
    key_load = 1'b0;
    check_val({tag, ".busy"},        64'(o_busy),      64'd1);
    check_val({tag, ".valid_early"}, 64'(o_out_valid), 64'd0);
    c = 0;
    while (!o_out_valid && c < 300) begin
      tick();
      c++;
    end
    check_val({tag, ".latency"}, 64'(c), 64'(lat));
    res = o_data;
  endtask

  task automatic finish_rec(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, ".valid_after"}, 64'(o_out_valid), 64'd0);
    check_val({tag, ".busy_after"},  64'(o_busy),      64'd0);
    check_val({tag, ".in_ready_after"}, 64'(o_in_ready), 64'd1);
  endtask

  localparam logic [63:0] K_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D_A = 64'hA5A5_0F0F_3C3C_7E81;

  initial begin
    logic [63:0] res;

    // ROUNDS=1 instance
    sel = 1'b0;
    do_reset();
    check_reset_vals("r1_reset");

    in_data  = 64'h1111_2222_3333_4444;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("nokey.in_ready",  64'(o_in_ready),  64'd0);
      check_val("nokey.out_valid", 64'(o_out_valid), 64'd0);
    end
    in_valid = 1'b0;
    load_key(64'h0);

    send_rec("r1_k0", 64'h0102_0304_0506_0708, 1'b0, 64'h0, 1, res);
    check_val("r1_k0.data", res, 64'h0203_0405_0607_0801);
`ifdef VOTE_CIPHER_TAG_EN
    check_val("r1_k0.tag", 64'(o_tag), 64'h08);
`endif
    finish_rec("r1_k0");

    load_key(64'hFFFF_FFFF_FFFF_FFFF);
    send_rec("r1_kf", 64'h0, 1'b0, 64'h0, 1, res);
    check_val("r1_kf.data", res, 64'hFFFF_FFFF_FFFF_FFFF);
    finish_rec("r1_kf");

    // key_load together with accept: record still uses all-ones key
    send_rec("r1_same", 64'h0, 1'b1, 64'h0, 1, res);
    check_val("r1_same.data", res, 64'hFFFF_FFFF_FFFF_FFFF);
    finish_rec("r1_same");
    send_rec("r1_newkey", 64'h0, 1'b0, 64'h0, 1, res);
    check_val("r1_newkey.data", res, 64'h0);
    finish_rec("r1_newkey");

    // ROUNDS=8 instance
    sel = 1'b1;
    do_reset();
    check_reset_vals("r8_reset");
    load_key(64'h0);
    send_rec("r8_z", 64'h0, 1'b0, 64'h0, 8, res);
    check_val("r8_z.data", res, 64'h0001_0003_0201_0400);

    out_ready = 1'b0;
    key_in    = 64'hDEAD_BEEF_CAFE_F00D;
    key_load  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("hold.data",      o_data,            64'h0001_0003_0201_0400);
      check_val("hold.out_valid", 64'(o_out_valid),  64'd1);
      check_val("hold.in_ready",  64'(o_in_ready),   64'd0);
    end
    key_load = 1'b0;
    finish_rec("r8_hold");
    send_rec("r8_rep", 64'h0, 1'b0, 64'h0, 8, res);
    check_val("r8_rep.data", res, 64'h0001_0003_0201_0400);
    finish_rec("r8_rep");

    // reset while in RUN with r=3
    load_key(K_A);
    in_data  = D_A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check_val("midrun.busy", 64'(o_busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("midrun_reset");
    tick();
    check_val("midrun.in_ready_nokey", 64'(o_in_ready), 64'd0);

    load_key(K_A);
    send_rec("r8_model", D_A, 1'b0, 64'h0, 8, res);
    check_val("r8_model.data", res, ref_cipher(K_A, D_A, 8));
`ifdef VOTE_CIPHER_TAG_EN
    check_val("r8_model.tag", 64'(o_tag),
              64'(D_A[63:56] ^ D_A[55:48] ^ D_A[47:40] ^ D_A[39:32] ^
                  D_A[31:24] ^ D_A[23:16] ^ D_A[15:8]  ^ D_A[7:0]));
`endif
    finish_rec("r8_model");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
